if_prefetch: RTL and testbench
==============================

Name: if_prefetch

Overview:
- Instruction-fetch stage directly upstream of the single-cycle rv32i core's decode/datapath.
- Issues sequential word fetches to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned {pc, instruction} pairs in a small FIFO and presents them to the core over a valid/ready handshake.
- A redirect, which the core's pc_sel/branch logic drives with the target PC, flushes the queue and discards stale in-flight responses.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >=2.
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered memory requests; must satisfy 1 <= MAX_OUTSTANDING <= DEPTH.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0); one clock only.
- redirect_valid  input  1  core requests a PC change this cycle.
- redirect_pc  input  32  new fetch target.
- imem_req_valid  output  1  fetch request offered.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  32  word address of the request (byte address, [1:0]=0).
- imem_rsp_valid  input  1  response data valid; responses arrive in request order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  fetched instruction.
- inst_valid  output  1  FIFO head valid toward the core.
- inst_ready  input  1  core consumes the head.
- inst_data  output  32  head instruction; NOP 32'h0000_0013 when inst_valid=0.
- inst_pc  output  32  PC of the head instruction.

Behaviour:
- Reset values (async assert):
  - imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=32'h0000_0013, inst_pc=RESET_PC.
  - FIFO empty; outstanding=0; drop_cnt=0; fetch_pc=RESET_PC; rsp_pc=RESET_PC; state=BOOT.
- State machine:
  - BOOT: one cycle with no request issued, then -> RUN.
  - RUN: normal operation; on redirect with drop_cnt_next>0 -> DRAIN.
  - DRAIN: drops responses while drop_cnt>0; -> RUN in the cycle drop_cnt reaches 0. A redirect in DRAIN reloads drop_cnt and stays in DRAIN if nonzero.
- Request issue (combinational):
  - imem_req_valid = (state!=BOOT) && !redirect_valid && (outstanding < MAX_OUTSTANDING) && (fifo_count + outstanding - drop_cnt < DEPTH).
  - imem_req_addr = fetch_pc.
  - Requests are per-cycle offers; addr/valid stability is not guaranteed across a redirect.
- On accept (valid && ready): fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0); outstanding += 1.
- On imem_rsp_valid: outstanding -= 1.
  - If drop_cnt>0: drop_cnt -= 1, data discarded.
  - Otherwise push {rsp_pc, imem_rsp_data}; rsp_pc += 4.
  - The credit check guarantees no push into a full FIFO; a push while full is an assertion failure.
- Pop: inst_valid && inst_ready. Push and pop in the same cycle leave the count unchanged, and a push into an empty FIFO is visible the next cycle (one-cycle fetch-to-core latency minimum).
- Redirect (highest priority):
  - FIFO cleared; fetch_pc and rsp_pc <= redirect_pc; no request is issued that cycle.
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0) + existing undropped accounting, i.e. every response still in flight after this cycle is dropped.
  - A simultaneous pop is ignored, and a simultaneous response is dropped.
- redirect_pc[1:0] != 0: the low bits are forced to 0.

Optional Feature:
- Macro IF_PREFETCH_PERF_EN.
- Defined: adds output stall_cycles (32 bits), reset 0. It increments, saturating at 32'hFFFF_FFFF, on each cycle with inst_ready=1 && inst_valid=0 && !redirect_valid.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package if_pkg holds:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst;}
  - enum if_state_t {BOOT, RUN, DRAIN}
  - constant RV_NOP = 32'h0000_0013
- Sub-module sync_fifo (parameterised width/DEPTH, push/pop/flush, count, full/empty) stores fetch_entry_t.

Test Plan:
- Reset, memory always ready, 1-cycle response latency -> first request addr 0x0 in cycle 2; core sees pcs 0x0, 0x4, 0x8 in order; inst_valid first high in cycle 4.
- Core holds inst_ready=0 -> exactly DEPTH=4 entries are fetched, then imem_req_valid stays 0; one pop re-enables exactly one request.
- Redirect to 0x100 with 2 requests outstanding -> the next 2 responses are dropped, the first delivered inst_pc is 0x100, and state passes through DRAIN back to RUN.
- Redirect in the same cycle as a response and a pop -> the response is dropped, the pop has no effect, FIFO is empty the next cycle, and drop_cnt = prior outstanding - 1.
- Redirect to 0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in that order.
- Assert reset mid-DRAIN with imem_req_ready=0 -> all outputs return to their reset values immediately; after release the first request is RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch prefetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } if_state_t;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; head is exposed combinationally.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: push while full is dropped and flagged; pop while empty is ignored; flush wins.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_L);
    assign empty   = (count == '0);
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Upstream credit accounting must make overflow impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && full));

endmodule

// File: rtl/if_prefetch.sv
// Sequential instruction prefetcher feeding the core through a small {pc, inst} FIFO.
// Latency: first request one cycle after reset, response to core-visible head is one cycle.
// Backpressure: requests gated by outstanding limit and FIFO credit; redirect flushes and drops stale responses.
// Optional stall counter output enabled by defining IF_PREFETCH_PERF_EN.
module if_prefetch
    import if_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] MAX_L   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

    if_state_t    state;
    if_state_t    state_next;
    logic [31:0]  fetch_pc;
    logic [31:0]  rsp_pc;
    logic [31:0]  redir_aligned;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_cnt_next;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          fifo_full;
    logic          fifo_empty;
    logic          req_fire;
    logic          rsp_push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic [63:0]   head_raw;

    assign redir_aligned = redirect_pc & ~32'h0000_0003;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign rsp_push      = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop           = inst_valid && inst_ready && !redirect_valid;
    assign push_entry    = '{pc: rsp_pc, inst: imem_rsp_data};
    assign head_entry    = fetch_entry_t'(head_raw);

    // Entries already queued plus those still coming back that will be kept.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - {1'b0, drop_cnt};

    // No request is issued in a redirect cycle, so req_fire is already zero there.
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    // Everything still in flight after a redirect cycle is stale and gets dropped.
    always_comb begin
        drop_cnt_next = drop_cnt;
        if (redirect_valid) begin
            drop_cnt_next = outstanding - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt_next = drop_cnt - CW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request-offer logic.
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (redirect_valid && (drop_cnt_next != '0)) state_next = DRAIN;
            DRAIN:   if (drop_cnt_next == '0) state_next = RUN;
            default: state_next = BOOT;
        endcase
        if ((state != BOOT) && !redirect_valid && (outstanding < MAX_L) &&
            (credit_used < DEPTH_L)) begin
            imem_req_valid = 1'b1;
        end
    end

    // Fetch/response PC tracking and in-flight accounting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
            if (redirect_valid) begin
                fetch_pc <= redir_aligned;
                rsp_pc   <= redir_aligned;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .flush    (redirect_valid),
        .push     (rsp_push),
        .push_dat (push_entry),
        .pop      (pop),
        .pop_dat  (head_raw),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign imem_req_addr = fetch_pc;
    assign inst_valid    = !fifo_empty;
    assign inst_data     = fifo_empty ? RV_NOP : head_entry.inst;
    // When empty, report the PC the next delivered instruction will carry.
    assign inst_pc       = fifo_empty ? rsp_pc : head_entry.pc;

`ifdef IF_PREFETCH_PERF_EN
    // Cycles where the core wanted an instruction but none was ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (inst_ready && !inst_valid && !redirect_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with a behavioural instruction memory and a {pc, inst} scoreboard.
// Latency: memory answers mem_lat cycles after acceptance unless held.
// Backpressure: core readiness and memory readiness driven per step.
module tb_if_prefetch;
    import if_pkg::*;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] stall_cycles;
`endif

    if_prefetch #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef IF_PREFETCH_PERF_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    bit mem_hold = 1'b0;
    int first_req_cyc = 0;
    int first_inst_cyc = 0;

    logic [31:0]  pend_addr [$];
    int           pend_due  [$];
    logic [31:0]  req_log   [$];
    logic [31:0]  pop_log   [$];
    fetch_entry_t exp_q     [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, observe mid-cycle, advance to just after the edge.
    task automatic tick();
        fetch_entry_t e;
        if (!mem_hold && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        @(negedge clk);
        if (redirect_valid) begin
            chk("no_req_on_redirect", 32'(imem_req_valid), 32'h0);
            exp_q.delete();
        end
        if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + mem_lat);
            req_log.push_back(imem_req_addr);
            if (first_req_cyc == 0) first_req_cyc = cyc;
            if (!redirect_valid) exp_q.push_back('{pc: imem_req_addr, inst: mem_word(imem_req_addr)});
        end
        if (!inst_valid) chk("nop_when_empty", inst_data, RV_NOP);
        if (inst_valid && first_inst_cyc == 0) first_inst_cyc = cyc;
        if (inst_valid && inst_ready && !redirect_valid) begin
            pop_log.push_back(inst_pc);
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", inst_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", inst_pc, e.pc);
                chk("pop_data", inst_data, e.inst);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int pidx;
        int ridx;

        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        #2;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_data", inst_data, RV_NOP);
        chk("rst_inst_pc", inst_pc, 32'h0);
`ifdef IF_PREFETCH_PERF_EN
        chk("rst_stall_cycles", stall_cycles, 32'h0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 1;

        // Startup: always-ready memory, 1-cycle latency, core always ready.
        inst_ready = 1'b1;
        ticks(8);
        chk("first_req_cycle", 32'(first_req_cyc), 32'd2);
        chk("first_req_addr", q_at(req_log, 0), 32'h0);
        chk("first_inst_cycle", 32'(first_inst_cyc), 32'd4);
        chk("pop_order_0", q_at(pop_log, 0), 32'h0);
        chk("pop_order_1", q_at(pop_log, 1), 32'h4);
        chk("pop_order_2", q_at(pop_log, 2), 32'h8);

        // Core stalls: exactly DEPTH fetches, then one pop buys exactly one more.
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        n0 = req_log.size();
        ticks(12);
        chk("fill_req_count", 32'(req_log.size() - n0), 32'd4);
        chk("fill_req_stopped", 32'(imem_req_valid), 32'h0);
        chk("fill_inst_valid", 32'(inst_valid), 32'h1);
        n0 = req_log.size();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        ticks(6);
        chk("refill_req_count", 32'(req_log.size() - n0), 32'd1);
        chk("refill_req_stopped", 32'(imem_req_valid), 32'h0);

        // Redirect with two requests outstanding: both responses dropped.
        mem_hold   = 1'b1;
        inst_ready = 1'b1;
        ticks(8);
        chk("pre_redir_outstanding", 32'(dut.outstanding), 32'd2);
        pidx           = pop_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("redir_state_drain", 32'(dut.state), 32'(DRAIN));
        chk("redir_drop_cnt", 32'(dut.drop_cnt), 32'd2);
        mem_hold = 1'b0;
        tick();
        chk("drain_state_mid", 32'(dut.state), 32'(DRAIN));
        tick();
        chk("drain_state_done", 32'(dut.state), 32'(RUN));
        ticks(8);
        chk("redir_first_pc", q_at(pop_log, pidx), 32'h100);

        // Redirect coinciding with a response and a pop; misaligned target.
        inst_ready = 1'b0;
        ticks(8);
        mem_hold   = 1'b1;
        inst_ready = 1'b1;
        ticks(2);
        inst_ready = 1'b0;
        ticks(3);
        chk("coinc_outstanding", 32'(dut.outstanding), 32'd2);
        chk("coinc_inst_valid", 32'(inst_valid), 32'h1);
        mem_hold       = 1'b0;
        inst_ready     = 1'b1;
        pidx           = pop_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        chk("coinc_fifo_empty", 32'(inst_valid), 32'h0);
        chk("coinc_drop_cnt", 32'(dut.drop_cnt), 32'd1);
        chk("coinc_state", 32'(dut.state), 32'(DRAIN));
        chk("coinc_aligned_addr", imem_req_addr, 32'h200);
        chk("coinc_pop_ignored", 32'(pop_log.size() - pidx), 32'd0);
        ticks(8);
        chk("coinc_first_pc", q_at(pop_log, pidx), 32'h200);

        // Address wrap at the top of the 32-bit space.
        ridx           = req_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        ticks(8);
        chk("wrap_addr_0", q_at(req_log, ridx), 32'hFFFF_FFF8);
        chk("wrap_addr_1", q_at(req_log, ridx + 1), 32'hFFFF_FFFC);
        chk("wrap_addr_2", q_at(req_log, ridx + 2), 32'h0000_0000);

        // Reset asserted mid-DRAIN with memory not ready.
        mem_hold = 1'b1;
        ticks(6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        chk("mid_drain_state", 32'(dut.state), 32'(DRAIN));
        reset = 1'b0;
        #1;
        chk("arst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("arst_req_addr", imem_req_addr, 32'h0);
        chk("arst_inst_valid", 32'(inst_valid), 32'h0);
        chk("arst_inst_data", inst_data, RV_NOP);
        chk("arst_inst_pc", inst_pc, 32'h0);
        chk("arst_state", 32'(dut.state), 32'(BOOT));
        pend_addr.delete();
        pend_due.delete();
        exp_q.delete();
        imem_rsp_valid = 1'b0;
        mem_hold       = 1'b0;
        @(posedge clk);
        #1;
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        cyc            = 1;
        first_req_cyc  = 0;
        ridx           = req_log.size();
        ticks(6);
        chk("post_rst_req_cycle", 32'(first_req_cyc), 32'd2);
        chk("post_rst_req_addr", q_at(req_log, ridx), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
